// File: rtl/axis_frame_sink.sv
// AXI-Stream frame sink: counts bytes per frame and emits a {len, bad, oversize} descriptor.
// Optional pseudo-random backpressure is compiled in with `define AXIS_FRAME_SINK_THROTTLE_EN.
module axis_frame_sink #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_LEN    = 1518
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [LEN_WIDTH-1:0]  m_desc_len,
  output logic                  m_desc_bad,
  output logic                  m_desc_oversize,
  output logic                  m_desc_valid,
  input  logic                  m_desc_ready,
  input  logic                  cfg_throttle_en,
  output logic [31:0]           stat_frames,
  output logic [31:0]           stat_bad
);

  localparam int PC_W  = $clog2(KEEP_WIDTH + 1);
  localparam int SUM_W = LEN_WIDTH + PC_W;
  localparam logic [SUM_W-1:0] LEN_SAT   = {{PC_W{1'b0}}, {LEN_WIDTH{1'b1}}};
  localparam logic [31:0]      MAX_LEN_U = MAX_LEN;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  function automatic logic [PC_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] acc_q, acc_d;
  logic                 run_q;
  logic                 desc_valid_q, desc_valid_d;
  logic [LEN_WIDTH-1:0] desc_len_q, desc_len_d;
  logic                 desc_bad_q, desc_bad_d;
  logic                 desc_over_q, desc_over_d;
  logic [31:0]          frames_q, frames_d;
  logic [31:0]          bad_cnt_q, bad_cnt_d;

  logic                 stall;
  logic                 beat_acc;
  logic [LEN_WIDTH-1:0] base_len;
  logic [SUM_W-1:0]     sum;
  logic [LEN_WIDTH-1:0] frame_len;
  logic                 frame_over;

`ifdef AXIS_FRAME_SINK_THROTTLE_EN
  logic [15:0] lfsr_q;
  logic        stall_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= 16'hACE1;
      stall_q <= 1'b0;
    end else begin
      lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
      stall_q <= cfg_throttle_en && (lfsr_q[1:0] == 2'b00);
    end
  end

  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

  // Data is sunk by design; fold the otherwise-unread inputs into one named sink.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tdata, s_axis_tuser, cfg_throttle_en};

  // run_q keeps tready low through reset and raises it on the first edge afterwards.
  assign s_axis_tready = run_q && !desc_valid_q && !stall;
  assign beat_acc      = s_axis_tvalid && s_axis_tready;

  assign base_len   = (state_q == RECV) ? acc_q : '0;
  assign sum        = SUM_W'(base_len) + SUM_W'(popcount(s_axis_tkeep));
  assign frame_len  = (sum > LEN_SAT) ? {LEN_WIDTH{1'b1}} : sum[LEN_WIDTH-1:0];
  assign frame_over = 32'(frame_len) > MAX_LEN_U;

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    desc_valid_d = desc_valid_q;
    desc_len_d   = desc_len_q;
    desc_bad_d   = desc_bad_q;
    desc_over_d  = desc_over_q;
    frames_d     = frames_q;
    bad_cnt_d    = bad_cnt_q;

    if (desc_valid_q && m_desc_ready) desc_valid_d = 1'b0;

    // An accepted beat implies no descriptor is pending, so the two branches never collide.
    if (beat_acc) begin
      if (s_axis_tlast) begin
        state_d      = IDLE;
        acc_d        = '0;
        desc_valid_d = 1'b1;
        desc_len_d   = frame_len;
        desc_bad_d   = s_axis_tuser[0];
        desc_over_d  = frame_over;
        frames_d     = frames_q + 32'd1;
        if (s_axis_tuser[0] || frame_over) bad_cnt_d = bad_cnt_q + 32'd1;
      end else begin
        state_d = RECV;
        acc_d   = frame_len;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      run_q        <= 1'b0;
      desc_valid_q <= 1'b0;
      desc_len_q   <= '0;
      desc_bad_q   <= 1'b0;
      desc_over_q  <= 1'b0;
      frames_q     <= '0;
      bad_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      run_q        <= 1'b1;
      desc_valid_q <= desc_valid_d;
      desc_len_q   <= desc_len_d;
      desc_bad_q   <= desc_bad_d;
      desc_over_q  <= desc_over_d;
      frames_q     <= frames_d;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

  assign m_desc_valid    = desc_valid_q;
  assign m_desc_len      = desc_len_q;
  assign m_desc_bad      = desc_bad_q;
  assign m_desc_oversize = desc_over_q;
  assign stat_frames     = frames_q;
  assign stat_bad        = bad_cnt_q;

endmodule
